// File: rtl/controle_partida_multifase_pkg.sv
// ---------------------------------------------------------------------------
// controle_partida_multifase_pkg
//
// Shared definitions for the multi-phase drone game controller:
//   - estado_t : state encoding (the value is also the 7-segment debug code)
//   - saidas_t : bundle of the 1-bit Moore outputs
//   - decodifica_saidas() : state -> Moore outputs decode
// ---------------------------------------------------------------------------
package controle_partida_multifase_pkg;

    typedef enum logic [3:0] {
        ST_INICIAL      = 4'h0,
        ST_PREPARACAO   = 4'h1,
        ST_MODO         = 4'h2,
        ST_ESPERA       = 4'h3,
        ST_DESLOCAMENTO = 4'h4,
        ST_CHECA        = 4'h5,
        ST_PROXIMO      = 4'h6,
        ST_DERROTA      = 4'h7,
        ST_VITORIA      = 4'h8,
        ST_VIDAS        = 4'h9,
        ST_ATUALIZA     = 4'hA,
        ST_TOUT         = 4'hB,
        ST_MAPA         = 4'hC,
        ST_PAUSA        = 4'hD,
        ST_RENASCE      = 4'hE
    } estado_t;

    typedef struct packed {
        logic zera_posicoes;
        logic escolhe_modo;
        logic escolhe_vida;
        logic escolhe_mapa;
        logic desloca;
        logic atualiza;
        logic checa_colisao;
        logic venceu;
        logic perdeu;
        logic timeout;
        logic pausado;
    } saidas_t;

    function automatic saidas_t decodifica_saidas(input estado_t st);
        saidas_t s;
        s               = '0;
        s.zera_posicoes = (st == ST_INICIAL) || (st == ST_PREPARACAO) ||
                          (st == ST_RENASCE);
        s.escolhe_modo  = (st == ST_MODO);
        s.escolhe_vida  = (st == ST_VIDAS);
        s.escolhe_mapa  = (st == ST_MAPA);
        s.desloca       = (st == ST_DESLOCAMENTO);
        s.atualiza      = (st == ST_ATUALIZA);
        s.checa_colisao = (st == ST_CHECA);
        s.venceu        = (st == ST_VITORIA);
        s.perdeu        = (st == ST_DERROTA);
        s.timeout       = (st == ST_TOUT);
        s.pausado       = (st == ST_PAUSA);
        return s;
    endfunction

endpackage

// File: rtl/controle_partida_multifase_contador_timeout.sv
// ---------------------------------------------------------------------------
// contador_timeout
//
// Idle-timeout counter. Counts while `conta` is high, clears on `zera`
// (zera has priority), and saturates at TIMEOUT_CICLOS-1 so it never wraps.
//
// Ports:
//   clock   in  : rising-edge clock
//   reset   in  : synchronous active-high reset, clears the count
//   zera    in  : clear the count on the next edge
//   conta   in  : increment the count on the next edge
//   expirou out : count has reached TIMEOUT_CICLOS-1
// ---------------------------------------------------------------------------
module contador_timeout #(
    parameter int TIMEOUT_CICLOS = 5000,
    parameter int W_T            = 13
) (
    input  logic clock,
    input  logic reset,
    input  logic zera,
    input  logic conta,
    output logic expirou
);

    logic [W_T-1:0] cnt_q;
    logic [W_T-1:0] cnt_d;

    assign expirou = (cnt_q == W_T'(TIMEOUT_CICLOS - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (zera) begin
            cnt_d = '0;
        end else if (conta && !expirou) begin
            cnt_d = cnt_q + W_T'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/controle_partida_multifase.sv
// ---------------------------------------------------------------------------
// controle_partida_multifase
//
// Moore control unit for the drone game: setup (mode, lives, map), then the
// move / collision loop with lives accounting and respawn, idle timeout,
// pause/resume and progression through N_FASES consecutive maps.
//
// Ports:
//   clock, reset          : single clock, synchronous active-high reset
//   iniciar               : start / restart from a terminal state
//   confirma              : confirm a setup step or resume from pause
//   pausa                 : pause request (only honoured in espera)
//   borda_movimento       : one-cycle move pulse (only honoured in espera)
//   colisao               : collision flag, sampled in checa_colisao
//   fim_mapa              : end of current map, sampled in proximo
//   vidas_sel [W_VIDAS]   : requested lives, sampled on confirma in vidas
//   mapa_sel  [W_FASE]    : starting phase, sampled on confirma in mapa
//   zeraPosicoes .. pausado : registered Moore strobes/levels
//   vidas_restantes       : current lives
//   fase_atual            : current map index
//   db_estado [4]         : current state code for the debug display
// ---------------------------------------------------------------------------
module controle_partida_multifase
    import controle_partida_multifase_pkg::*;
#(
    parameter int MAX_VIDAS      = 3,
    parameter int W_VIDAS        = 2,
    parameter int N_FASES        = 4,
    parameter int W_FASE         = 2,
    parameter int TIMEOUT_CICLOS = 5000,
    parameter int W_T            = 13
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               iniciar,
    input  logic               confirma,
    input  logic               pausa,
    input  logic               borda_movimento,
    input  logic               colisao,
    input  logic               fim_mapa,
    input  logic [W_VIDAS-1:0] vidas_sel,
    input  logic [W_FASE-1:0]  mapa_sel,
    output logic               zeraPosicoes,
    output logic               escolhe_modo,
    output logic               escolhe_vida,
    output logic               escolhe_mapa,
    output logic               desloca,
    output logic               atualiza_out,
    output logic               checa_colisao_out,
    output logic               venceu,
    output logic               perdeu,
    output logic               timeout_out,
    output logic               pausado,
    output logic [W_VIDAS-1:0] vidas_restantes,
    output logic [W_FASE-1:0]  fase_atual,
    output logic [3:0]         db_estado
);

    estado_t            state_q, state_d;
    logic [W_VIDAS-1:0] vidas_q, vidas_d;
    logic [W_FASE-1:0]  fase_q, fase_d;
    saidas_t            saidas_q;

    logic timer_zera;
    logic timer_conta;
    logic timer_expirou;

    // Timer counts only while waiting for a move; it is left untouched in
    // pausa so that resuming continues the same idle budget.
    assign timer_zera  = (state_q == ST_INICIAL) || (state_q == ST_PREPARACAO) ||
                         (state_q == ST_RENASCE) || (state_q == ST_PROXIMO);
    assign timer_conta = (state_q == ST_ESPERA);

    contador_timeout #(
        .TIMEOUT_CICLOS (TIMEOUT_CICLOS),
        .W_T            (W_T)
    ) u_timer (
        .clock   (clock),
        .reset   (reset),
        .zera    (timer_zera),
        .conta   (timer_conta),
        .expirou (timer_expirou)
    );

    always_comb begin
        state_d = state_q;
        vidas_d = vidas_q;
        fase_d  = fase_q;
        case (state_q)
            ST_INICIAL: begin
                vidas_d = '0;
                fase_d  = '0;
                if (iniciar) state_d = ST_MODO;
            end
            ST_MODO: begin
                vidas_d = '0;
                fase_d  = '0;
                if (confirma) state_d = ST_VIDAS;
            end
            ST_VIDAS: begin
                if (confirma) begin
                    state_d = ST_MAPA;
                    // Zero lives or more than the maximum is treated as
                    // "no valid choice" and grants the maximum.
                    if ((vidas_sel == '0) || (int'(vidas_sel) > MAX_VIDAS)) begin
                        vidas_d = W_VIDAS'(MAX_VIDAS);
                    end else begin
                        vidas_d = vidas_sel;
                    end
                end
            end
            ST_MAPA: begin
                if (confirma) begin
                    state_d = ST_PREPARACAO;
                    if (int'(mapa_sel) >= N_FASES) begin
                        fase_d = W_FASE'(N_FASES - 1);
                    end else begin
                        fase_d = mapa_sel;
                    end
                end
            end
            ST_PREPARACAO: state_d = ST_ESPERA;
            ST_ESPERA: begin
                // Expiry outranks everything, so a move arriving on the
                // expiry cycle is dropped.
                if (timer_expirou)        state_d = ST_TOUT;
                else if (pausa)           state_d = ST_PAUSA;
                else if (borda_movimento) state_d = ST_DESLOCAMENTO;
            end
            ST_DESLOCAMENTO: state_d = ST_ATUALIZA;
            ST_ATUALIZA:     state_d = ST_CHECA;
            ST_CHECA: begin
                if (colisao) begin
                    if (vidas_q <= W_VIDAS'(1)) begin
                        state_d = ST_DERROTA;
                        vidas_d = '0;
                    end else begin
                        state_d = ST_RENASCE;
                        vidas_d = vidas_q - W_VIDAS'(1);
                    end
                end else begin
                    state_d = ST_PROXIMO;
                end
            end
            ST_RENASCE: state_d = ST_ESPERA;
            ST_PROXIMO: begin
                if (!fim_mapa) begin
                    state_d = ST_ESPERA;
                end else if (int'(fase_q) < N_FASES - 1) begin
                    state_d = ST_PREPARACAO;
                    fase_d  = fase_q + W_FASE'(1);
                end else begin
                    state_d = ST_VITORIA;
                end
            end
            ST_PAUSA: begin
                if (confirma) state_d = ST_ESPERA;
            end
            ST_DERROTA, ST_VITORIA, ST_TOUT: begin
                if (iniciar) state_d = ST_MODO;
            end
            default: state_d = ST_INICIAL;
        endcase
    end

    // Outputs are decoded from the next state so they line up with state_q.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= ST_INICIAL;
            vidas_q  <= '0;
            fase_q   <= '0;
            saidas_q <= decodifica_saidas(ST_INICIAL);
        end else begin
            state_q  <= state_d;
            vidas_q  <= vidas_d;
            fase_q   <= fase_d;
            saidas_q <= decodifica_saidas(state_d);
        end
    end

    assign zeraPosicoes      = saidas_q.zera_posicoes;
    assign escolhe_modo      = saidas_q.escolhe_modo;
    assign escolhe_vida      = saidas_q.escolhe_vida;
    assign escolhe_mapa      = saidas_q.escolhe_mapa;
    assign desloca           = saidas_q.desloca;
    assign atualiza_out      = saidas_q.atualiza;
    assign checa_colisao_out = saidas_q.checa_colisao;
    assign venceu            = saidas_q.venceu;
    assign perdeu            = saidas_q.perdeu;
    assign timeout_out       = saidas_q.timeout;
    assign pausado           = saidas_q.pausado;
    assign vidas_restantes   = vidas_q;
    assign fase_atual        = fase_q;
    assign db_estado         = state_q;

endmodule

// File: tb/tb_controle_partida_multifase.sv
module tb_controle_partida_multifase;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       iniciar = 1'b0;
    logic       confirma = 1'b0;
    logic       pausa = 1'b0;
    logic       borda_movimento = 1'b0;
    logic       colisao = 1'b0;
    logic       fim_mapa = 1'b0;
    logic [1:0] vidas_sel = 2'd0;
    logic [1:0] mapa_sel = 2'd0;
    logic       zeraPosicoes, escolhe_modo, escolhe_vida, escolhe_mapa;
    logic       desloca, atualiza_out, checa_colisao_out;
    logic       venceu, perdeu, timeout_out, pausado;
    logic [1:0] vidas_restantes;
    logic [1:0] fase_atual;
    logic [3:0] db_estado;

    int n_cmp = 0;
    int n_err = 0;

    controle_partida_multifase #(
        .MAX_VIDAS      (3),
        .W_VIDAS        (2),
        .N_FASES        (4),
        .W_FASE         (2),
        .TIMEOUT_CICLOS (8),
        .W_T            (4)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .iniciar           (iniciar),
        .confirma          (confirma),
        .pausa             (pausa),
        .borda_movimento   (borda_movimento),
        .colisao           (colisao),
        .fim_mapa          (fim_mapa),
        .vidas_sel         (vidas_sel),
        .mapa_sel          (mapa_sel),
        .zeraPosicoes      (zeraPosicoes),
        .escolhe_modo      (escolhe_modo),
        .escolhe_vida      (escolhe_vida),
        .escolhe_mapa      (escolhe_mapa),
        .desloca           (desloca),
        .atualiza_out      (atualiza_out),
        .checa_colisao_out (checa_colisao_out),
        .venceu            (venceu),
        .perdeu            (perdeu),
        .timeout_out       (timeout_out),
        .pausado           (pausado),
        .vidas_restantes   (vidas_restantes),
        .fase_atual        (fase_atual),
        .db_estado         (db_estado)
    );

    // ---------------- clock ----------------
    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic apply_reset();
        iniciar = 0; confirma = 0; pausa = 0; borda_movimento = 0;
        colisao = 0; fim_mapa = 0;
        reset = 1;
        step();
        reset = 0;
    endtask

    // Leaves the DUT in espera with the timer freshly cleared.
    task automatic setup_to_espera(input logic [1:0] vs, input logic [1:0] ms);
        apply_reset();
        iniciar = 1; step(); iniciar = 0;          // modo
        confirma = 1; step();                      // vidas
        vidas_sel = vs; step();                    // mapa
        mapa_sel = ms; step();                     // preparacao
        confirma = 0; step();                      // espera
    endtask

    // espera -> deslocamento -> atualiza_posicao -> checa_colisao
    task automatic move_to_checa();
        borda_movimento = 1; step();
        borda_movimento = 0; step();
        step();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        apply_reset();
        n_cmp++; if (db_estado !== 4'h0) begin n_err++; $display("FAIL reset_db got %h want 0", db_estado); end
        n_cmp++; if (zeraPosicoes !== 1'b1) begin n_err++; $display("FAIL reset_zera got %b want 1", zeraPosicoes); end
        n_cmp++; if ({escolhe_modo, escolhe_vida, escolhe_mapa, desloca, atualiza_out, checa_colisao_out,
                      venceu, perdeu, timeout_out, pausado} !== 10'b0) begin
            n_err++; $display("FAIL reset_strobes got nonzero want 0");
        end
        n_cmp++; if ({vidas_restantes, fase_atual} !== 4'b0) begin n_err++; $display("FAIL reset_regs got %b want 0000", {vidas_restantes, fase_atual}); end

        setup_to_espera(2'd2, 2'd1);
        n_cmp++; if (db_estado !== 4'h3) begin n_err++; $display("FAIL setup_db got %h want 3", db_estado); end
        n_cmp++; if (vidas_restantes !== 2'd2) begin n_err++; $display("FAIL setup_vidas got %0d want 2", vidas_restantes); end
        n_cmp++; if (fase_atual !== 2'd1) begin n_err++; $display("FAIL setup_fase got %0d want 1", fase_atual); end

        // Reset mid-play while a move also arrives.
        reset = 1; borda_movimento = 1; step(); reset = 0; borda_movimento = 0;
        n_cmp++; if (db_estado !== 4'h0) begin n_err++; $display("FAIL midreset_db got %h want 0", db_estado); end
        n_cmp++; if ({vidas_restantes, fase_atual} !== 4'b0) begin n_err++; $display("FAIL midreset_regs got %b want 0000", {vidas_restantes, fase_atual}); end
        n_cmp++; if (zeraPosicoes !== 1'b1) begin n_err++; $display("FAIL midreset_zera got %b want 1", zeraPosicoes); end
    endtask

    task automatic test_vidas_colisao();
        setup_to_espera(2'd0, 2'd0);
        n_cmp++; if (vidas_restantes !== 2'd3) begin n_err++; $display("FAIL vidas_default got %0d want 3", vidas_restantes); end
        for (int k = 0; k < 3; k++) begin
            borda_movimento = 1; step(); borda_movimento = 0;
            n_cmp++; if (db_estado !== 4'h4 || desloca !== 1'b1) begin n_err++; $display("FAIL move_desloca k=%0d got db=%h desloca=%b want 4/1", k, db_estado, desloca); end
            step();
            n_cmp++; if (db_estado !== 4'hA || atualiza_out !== 1'b1) begin n_err++; $display("FAIL move_atualiza k=%0d got db=%h want A", k, db_estado); end
            step();
            n_cmp++; if (db_estado !== 4'h5 || checa_colisao_out !== 1'b1) begin n_err++; $display("FAIL move_checa k=%0d got db=%h want 5", k, db_estado); end
            colisao = 1; step(); colisao = 0;
            if (k < 2) begin
                n_cmp++; if (db_estado !== 4'hE || zeraPosicoes !== 1'b1) begin n_err++; $display("FAIL renasce k=%0d got db=%h want E", k, db_estado); end
                n_cmp++; if (vidas_restantes !== 2'(2 - k)) begin n_err++; $display("FAIL renasce_vidas k=%0d got %0d want %0d", k, vidas_restantes, 2 - k); end
                step();
                n_cmp++; if (db_estado !== 4'h3) begin n_err++; $display("FAIL renasce_espera k=%0d got %h want 3", k, db_estado); end
            end else begin
                n_cmp++; if (db_estado !== 4'h7 || perdeu !== 1'b1) begin n_err++; $display("FAIL derrota got db=%h perdeu=%b want 7/1", db_estado, perdeu); end
                n_cmp++; if (vidas_restantes !== 2'd0) begin n_err++; $display("FAIL derrota_vidas got %0d want 0", vidas_restantes); end
            end
        end
        iniciar = 1; step(); iniciar = 0;
        n_cmp++; if (db_estado !== 4'h2 || escolhe_modo !== 1'b1) begin n_err++; $display("FAIL restart_derrota got db=%h want 2", db_estado); end
    endtask

    task automatic test_fases();
        setup_to_espera(2'd2, 2'd2);
        n_cmp++; if (fase_atual !== 2'd2) begin n_err++; $display("FAIL fase_sel got %0d want 2", fase_atual); end
        move_to_checa(); colisao = 0; step();
        n_cmp++; if (db_estado !== 4'h6) begin n_err++; $display("FAIL proximo got %h want 6", db_estado); end
        fim_mapa = 0; step();
        n_cmp++; if (db_estado !== 4'h3) begin n_err++; $display("FAIL proximo_espera got %h want 3", db_estado); end
        move_to_checa(); step();
        fim_mapa = 1; step(); fim_mapa = 0;
        n_cmp++; if (db_estado !== 4'h1 || fase_atual !== 2'd3) begin n_err++; $display("FAIL fase_avanca got db=%h fase=%0d want 1/3", db_estado, fase_atual); end
        step();
        move_to_checa(); step();
        fim_mapa = 1; step(); fim_mapa = 0;
        n_cmp++; if (db_estado !== 4'h8 || venceu !== 1'b1) begin n_err++; $display("FAIL vitoria got db=%h venceu=%b want 8/1", db_estado, venceu); end
        n_cmp++; if (fase_atual !== 2'd3) begin n_err++; $display("FAIL vitoria_fase got %0d want 3", fase_atual); end
    endtask

    task automatic test_timeout();
        setup_to_espera(2'd1, 2'd0);
        confirma = 1;   // ignored in espera
        for (int i = 1; i < 8; i++) begin
            step();
            n_cmp++; if (db_estado !== 4'h3) begin n_err++; $display("FAIL timeout_wait i=%0d got %h want 3", i, db_estado); end
        end
        step();
        confirma = 0;
        n_cmp++; if (db_estado !== 4'hB || timeout_out !== 1'b1) begin n_err++; $display("FAIL timeout got db=%h tout=%b want B/1", db_estado, timeout_out); end
        iniciar = 1; step(); iniciar = 0;
        n_cmp++; if (db_estado !== 4'h2) begin n_err++; $display("FAIL restart_tout got %h want 2", db_estado); end
    endtask

    task automatic test_pausa();
        setup_to_espera(2'd1, 2'd0);
        step(); step();
        pausa = 1; step();
        n_cmp++; if (db_estado !== 4'hD || pausado !== 1'b1) begin n_err++; $display("FAIL pausa got db=%h pausado=%b want D/1", db_estado, pausado); end
        borda_movimento = 1;
        for (int i = 0; i < 19; i++) step();
        n_cmp++; if (db_estado !== 4'hD) begin n_err++; $display("FAIL pausa_hold got %h want D", db_estado); end
        pausa = 0; borda_movimento = 0;
        confirma = 1; step(); confirma = 0;
        n_cmp++; if (db_estado !== 4'h3) begin n_err++; $display("FAIL resume got %h want 3", db_estado); end
        for (int i = 1; i < 5; i++) begin
            step();
            n_cmp++; if (db_estado !== 4'h3) begin n_err++; $display("FAIL resume_wait i=%0d got %h want 3", i, db_estado); end
        end
        step();
        n_cmp++; if (db_estado !== 4'hB) begin n_err++; $display("FAIL resume_timeout got %h want B", db_estado); end
    endtask

    task automatic test_expiry_vs_move();
        setup_to_espera(2'd1, 2'd0);
        for (int i = 0; i < 7; i++) step();
        borda_movimento = 1; pausa = 1; step();
        borda_movimento = 0; pausa = 0;
        n_cmp++; if (db_estado !== 4'hB) begin n_err++; $display("FAIL expiry_prio got %h want B", db_estado); end
        n_cmp++; if (desloca !== 1'b0) begin n_err++; $display("FAIL expiry_desloca got %b want 0", desloca); end
        step();
        n_cmp++; if (db_estado !== 4'hB || desloca !== 1'b0) begin n_err++; $display("FAIL expiry_hold got db=%h desloca=%b want B/0", db_estado, desloca); end
    endtask

    task automatic test_reset_in_pausa();
        setup_to_espera(2'd2, 2'd3);
        pausa = 1; step(); pausa = 0;
        n_cmp++; if (db_estado !== 4'hD) begin n_err++; $display("FAIL pausa_enter got %h want D", db_estado); end
        reset = 1; confirma = 1; step(); reset = 0; confirma = 0;
        n_cmp++; if (db_estado !== 4'h0 || pausado !== 1'b0) begin n_err++; $display("FAIL pausa_reset got db=%h pausado=%b want 0/0", db_estado, pausado); end
        n_cmp++; if ({vidas_restantes, fase_atual} !== 4'b0) begin n_err++; $display("FAIL pausa_reset_regs got %b want 0000", {vidas_restantes, fase_atual}); end
    endtask

    initial begin
        test_reset();
        test_vidas_colisao();
        test_fases();
        test_timeout();
        test_pausa();
        test_expiry_vs_move();
        test_reset_in_pausa();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
